// File: rtl/rv_pkg.sv
// Shared RV32I definitions used by the decode/execute boundary logic.
// Contents: default datapath width, base opcode constants and the opcode
// loaded into an empty pipeline slot (addi x0,x0,0).
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // A bubble in EX looks like addi x0,x0,0 so forwarding never matches it.
  localparam logic [6:0] NOP_OPCODE = OP_I;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard detection.
// Decides from the ID opcode which source registers are really read, then
// flags a hazard when the load sitting in EX writes one of them.
// Ports:
//   valid_id        ID holds a real instruction
//   opcode_id       ID opcode
//   rs1_id, rs2_id  ID source register indices
//   mem_read_ex     EX instruction is a load
//   rd_ex           EX destination register
//   uses_rs1        ID instruction reads rs1
//   uses_rs2        ID instruction reads rs2
//   lu_hz           load-use hazard
module load_use_detect
  import rv_pkg::*;
(
  input  logic       valid_id,
  input  logic [6:0] opcode_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       mem_read_ex,
  input  logic [4:0] rd_ex,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       lu_hz
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  // Source-operand decode: LUI/AUIPC/JAL carry immediate bits in the rs1 slot.
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode_id)
      OP_LUI, OP_AUIPC, OP_JAL: uses_rs1 = 1'b0;
      default:                  uses_rs1 = 1'b1;
    endcase
    case (opcode_id)
      OP_R, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
      default:                   uses_rs2 = 1'b0;
    endcase
  end

  // Hazard match: a load to x0 never produces a value worth waiting for.
  always_comb begin
    rs1_hit_s = uses_rs1 && (rd_ex == rs1_id);
    rs2_hit_s = uses_rs2 && (rd_ex == rs2_id);
    if (valid_id && mem_read_ex && (rd_ex != 5'd0)) begin
      lu_hz = rs1_hit_s || rs2_hit_s;
    end else begin
      lu_hz = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage RV32I core.
// Captures decoded operands, register indices, immediate and control from
// ID; inserts a bubble on branch flush, on load-use hazard and when ID is
// empty; holds everything while the downstream memory stage stalls.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   *_id                       decoded ID instruction fields and control
//   stall_i                    downstream hold, freezes this register
//   flush_i                    taken branch/jump in EX, kills ID instruction
//   stall_o                    load-use stall request to PC and IF/ID
//   *_ex                       registered EX copies of the ID fields
//   lu_cnt, flush_cnt          saturating bubble event counters
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_id,
  input  logic [XLEN-1:0]   pc_id,
  input  logic [6:0]        opcode_id,
  input  logic [2:0]        funct3_id,
  input  logic              funct7b5_id,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic [4:0]        rd_id,
  input  logic [XLEN-1:0]   rs1_data_id,
  input  logic [XLEN-1:0]   rs2_data_id,
  input  logic [XLEN-1:0]   imm_id,
  input  logic              RegWrite_id,
  input  logic              MemRead_id,
  input  logic              MemWrite_id,
  input  logic              MemToReg_id,
  input  logic              ALUSrc_id,
  input  logic              Branch_id,
  input  logic              Jump_id,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              valid_ex,
  output logic [XLEN-1:0]   pc_ex,
  output logic [6:0]        opcode_ex,
  output logic [2:0]        funct3_ex,
  output logic              funct7b5_ex,
  output logic [4:0]        rs1_ex,
  output logic [4:0]        rs2_ex,
  output logic [4:0]        rd_ex,
  output logic [XLEN-1:0]   rs1_data_ex,
  output logic [XLEN-1:0]   rs2_data_ex,
  output logic [XLEN-1:0]   imm_ex,
  output logic              RegWrite_ex,
  output logic              MemRead_ex,
  output logic              MemWrite_ex,
  output logic              MemToReg_ex,
  output logic              ALUSrc_ex,
  output logic              Branch_ex,
  output logic              Jump_ex,
  output logic [CNT_W-1:0]  lu_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            branch;
    logic            jump;
  } ex_t;

  function automatic ex_t bubble();
    ex_t b;
    b        = '0;
    b.opcode = NOP_OPCODE;
    return b;
  endfunction

  ex_t              ex_r;
  ex_t              ex_d_s;
  ex_t              id_s;
  logic [CNT_W-1:0] lu_cnt_r;
  logic [CNT_W-1:0] lu_cnt_d_s;
  logic [CNT_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0] flush_cnt_d_s;
  logic             lu_hz_s;
  logic             uses_rs1_s;
  logic             uses_rs2_s;
  logic             unused_s;

  load_use_detect u_load_use_detect (
    .valid_id    (valid_id),
    .opcode_id   (opcode_id),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .mem_read_ex (ex_r.mem_read),
    .rd_ex       (ex_r.rd),
    .uses_rs1    (uses_rs1_s),
    .uses_rs2    (uses_rs2_s),
    .lu_hz       (lu_hz_s)
  );

  // The source-use decode is shared with the decoder; only lu_hz is needed here.
  assign unused_s = &{1'b0, uses_rs1_s, uses_rs2_s};

  // A taken branch kills the ID instruction, so it must not also stall upstream.
  assign stall_o = lu_hz_s & ~flush_i;

  // Gather the ID fields into the EX record layout.
  always_comb begin
    id_s            = '0;
    id_s.valid      = valid_id;
    id_s.pc         = pc_id;
    id_s.opcode     = opcode_id;
    id_s.funct3     = funct3_id;
    id_s.funct7b5   = funct7b5_id;
    id_s.rs1        = rs1_id;
    id_s.rs2        = rs2_id;
    id_s.rd         = rd_id;
    id_s.rs1_data   = rs1_data_id;
    id_s.rs2_data   = rs2_data_id;
    id_s.imm        = imm_id;
    id_s.reg_write  = RegWrite_id;
    id_s.mem_read   = MemRead_id;
    id_s.mem_write  = MemWrite_id;
    id_s.mem_to_reg = MemToReg_id;
    id_s.alu_src    = ALUSrc_id;
    id_s.branch     = Branch_id;
    id_s.jump       = Jump_id;
  end

  // Next-state selection: hold > flush > load-use > capture.
  always_comb begin
    ex_d_s        = ex_r;
    lu_cnt_d_s    = lu_cnt_r;
    flush_cnt_d_s = flush_cnt_r;
    if (stall_i) begin
      // Flush is ignored here; the branch stays in EX and re-asserts it.
      ex_d_s = ex_r;
    end else if (flush_i) begin
      ex_d_s = bubble();
      if (flush_cnt_r != {CNT_W{1'b1}}) begin
        flush_cnt_d_s = flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_d_s = flush_cnt_r;
      end
    end else if (lu_hz_s) begin
      // ID is held upstream and re-presented next cycle.
      ex_d_s = bubble();
      if (lu_cnt_r != {CNT_W{1'b1}}) begin
        lu_cnt_d_s = lu_cnt_r + CNT_W'(1);
      end else begin
        lu_cnt_d_s = lu_cnt_r;
      end
    end else if (valid_id) begin
      ex_d_s = id_s;
    end else begin
      ex_d_s = bubble();
    end
  end

  // Pipeline register and counters; reset loads the bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r        <= bubble();
      lu_cnt_r    <= '0;
      flush_cnt_r <= '0;
    end else begin
      ex_r        <= ex_d_s;
      lu_cnt_r    <= lu_cnt_d_s;
      flush_cnt_r <= flush_cnt_d_s;
    end
  end

  assign valid_ex    = ex_r.valid;
  assign pc_ex       = ex_r.pc;
  assign opcode_ex   = ex_r.opcode;
  assign funct3_ex   = ex_r.funct3;
  assign funct7b5_ex = ex_r.funct7b5;
  assign rs1_ex      = ex_r.rs1;
  assign rs2_ex      = ex_r.rs2;
  assign rd_ex       = ex_r.rd;
  assign rs1_data_ex = ex_r.rs1_data;
  assign rs2_data_ex = ex_r.rs2_data;
  assign imm_ex      = ex_r.imm;
  assign RegWrite_ex = ex_r.reg_write;
  assign MemRead_ex  = ex_r.mem_read;
  assign MemWrite_ex = ex_r.mem_write;
  assign MemToReg_ex = ex_r.mem_to_reg;
  assign ALUSrc_ex   = ex_r.alu_src;
  assign Branch_ex   = ex_r.branch;
  assign Jump_ex     = ex_r.jump;
  assign lu_cnt      = lu_cnt_r;
  assign flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios followed by
// randomized traffic, checked by a scoreboard against a reference model.
// Counters use a narrow width so saturation is reached within the run.
module tb_id_ex_stage;
  import rv_pkg::*;

  localparam int XL = 32;
  localparam int CW = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_id = 1'b0;
  logic [XL-1:0] pc_id = '0, rs1_data_id = '0, rs2_data_id = '0, imm_id = '0;
  logic [6:0] opcode_id = 7'b0010011;
  logic [2:0] funct3_id = 3'd0;
  logic funct7b5_id = 1'b0;
  logic [4:0] rs1_id = 5'd0, rs2_id = 5'd0, rd_id = 5'd0;
  logic RegWrite_id = 1'b0, MemRead_id = 1'b0, MemWrite_id = 1'b0, MemToReg_id = 1'b0;
  logic ALUSrc_id = 1'b0, Branch_id = 1'b0, Jump_id = 1'b0;
  logic stall_i = 1'b0, flush_i = 1'b0;
  logic stall_o, valid_ex, funct7b5_ex;
  logic [XL-1:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [6:0] opcode_ex;
  logic [2:0] funct3_ex;
  logic [4:0] rs1_ex, rs2_ex, rd_ex;
  logic RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex, ALUSrc_ex, Branch_ex, Jump_ex;
  logic [CW-1:0] lu_cnt, flush_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .pc_id(pc_id),
    .opcode_id(opcode_id), .funct3_id(funct3_id), .funct7b5_id(funct7b5_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
    .MemToReg_id(MemToReg_id), .ALUSrc_id(ALUSrc_id), .Branch_id(Branch_id),
    .Jump_id(Jump_id), .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o),
    .valid_ex(valid_ex), .pc_ex(pc_ex), .opcode_ex(opcode_ex), .funct3_ex(funct3_ex),
    .funct7b5_ex(funct7b5_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemToReg_ex(MemToReg_ex), .ALUSrc_ex(ALUSrc_ex), .Branch_ex(Branch_ex),
    .Jump_ex(Jump_ex), .lu_cnt(lu_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic          valid;
    logic [XL-1:0] pc;
    logic [6:0]    op;
    logic [2:0]    f3;
    logic          f7;
    logic [4:0]    rs1, rs2, rd;
    logic [XL-1:0] d1, d2, imm;
    logic          rw, mr, mw, m2r, as, br, jp;
  } inst_t;

  typedef struct {
    inst_t ex;
    int    lu;
    int    fl;
  } exp_t;

  exp_t  sb_q[$];
  inst_t m_ex;
  int    m_lu, m_fl;
  int    n_cmp = 0;
  int    n_bad = 0;
  exp_t  mon_e;
  inst_t mon_act;

  function automatic inst_t bub();
    inst_t b;
    b    = '0;
    b.op = 7'b0010011;
    return b;
  endfunction

  function automatic inst_t actual_ex();
    return {valid_ex, pc_ex, opcode_ex, funct3_ex, funct7b5_ex, rs1_ex, rs2_ex, rd_ex,
            rs1_data_ex, rs2_data_ex, imm_ex, RegWrite_ex, MemRead_ex, MemWrite_ex,
            MemToReg_ex, ALUSrc_ex, Branch_ex, Jump_ex};
  endfunction

  // Build an ID instruction; data fields are random, controls follow the opcode.
  function automatic inst_t mk(input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    inst_t i;
    i.valid = 1'b1; i.pc = $urandom; i.op = op; i.f3 = 3'($urandom); i.f7 = 1'($urandom);
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom;
    i.mr = (op == 7'b0000011); i.m2r = i.mr; i.rw = (op != 7'b0100011) && (op != 7'b1100011);
    i.mw = (op == 7'b0100011); i.as = (op != 7'b0110011);
    i.br = (op == 7'b1100011); i.jp = (op == 7'b1101111) || (op == 7'b1100111);
    return i;
  endfunction

  // Reference rule: does the ID instruction need the value the EX load produces?
  function automatic bit ref_hazard(input inst_t ex, input inst_t id);
    bit reads1, reads2;
    reads1 = !(id.op inside {7'b0110111, 7'b0010111, 7'b1101111});
    reads2 = id.op inside {7'b0110011, 7'b0100011, 7'b1100011};
    if (!id.valid || !ex.mr || ex.rd == 5'd0) return 1'b0;
    return (reads1 && ex.rd == id.rs1) || (reads2 && ex.rd == id.rs2);
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Present one ID instruction for a cycle, check stall_o, queue the expected EX state.
  task automatic apply(input inst_t id, input logic st, input logic fl);
    bit   hz;
    exp_t e;
    @(negedge clk);
    valid_id = id.valid; pc_id = id.pc; opcode_id = id.op; funct3_id = id.f3;
    funct7b5_id = id.f7; rs1_id = id.rs1; rs2_id = id.rs2; rd_id = id.rd;
    rs1_data_id = id.d1; rs2_data_id = id.d2; imm_id = id.imm;
    RegWrite_id = id.rw; MemRead_id = id.mr; MemWrite_id = id.mw; MemToReg_id = id.m2r;
    ALUSrc_id = id.as; Branch_id = id.br; Jump_id = id.jp;
    stall_i = st; flush_i = fl;
    #1;
    hz = ref_hazard(m_ex, id);
    check_bit("stall_o", stall_o, hz && !fl);
    if (st) begin
      // register frozen
    end else if (fl) begin
      m_ex = bub(); m_fl = (m_fl < CNT_MAX) ? m_fl + 1 : CNT_MAX;
    end else if (hz) begin
      m_ex = bub(); m_lu = (m_lu < CNT_MAX) ? m_lu + 1 : CNT_MAX;
    end else if (id.valid) begin
      m_ex = id;
    end else begin
      m_ex = bub();
    end
    e.ex = m_ex; e.lu = m_lu; e.fl = m_fl;
    sb_q.push_back(e);
  endtask

  // Monitor: after every active edge compare the EX register against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = actual_ex();
      n_cmp++;
      if (mon_act !== mon_e.ex) begin
        n_bad++;
        $display("FAIL ex_regs: got %h expected %h at %0t", mon_act, mon_e.ex, $time);
      end
      n_cmp++;
      if (int'(lu_cnt) != mon_e.lu || int'(flush_cnt) != mon_e.fl) begin
        n_bad++;
        $display("FAIL counters: got lu=%0d fl=%0d expected lu=%0d fl=%0d at %0t",
                 lu_cnt, flush_cnt, mon_e.lu, mon_e.fl, $time);
      end
    end
  end

  task automatic check_reset_state(input string name);
    n_cmp++;
    if (actual_ex() !== bub() || lu_cnt !== '0 || flush_cnt !== '0 || stall_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got ex=%h lu=%0d fl=%0d stall=%b expected ex=%h lu=0 fl=0 stall=0",
               name, actual_ex(), lu_cnt, flush_cnt, stall_o, bub());
    end
  endtask

  function automatic inst_t rnd_inst();
    logic [6:0] ops [9];
    inst_t i;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    i = mk(($urandom % 10 == 0) ? 7'($urandom) : ops[$urandom % 9],
           5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4));
    i.valid = ($urandom % 6 != 0);
    if ($urandom % 8 == 0) i.mr = ~i.mr;
    return i;
  endfunction

  initial begin
    inst_t a, b;
    m_ex = bub(); m_lu = 0; m_fl = 0;
    repeat (2) @(negedge clk);
    check_reset_state("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: lw x5 then add x6,x5,x7 -> one bubble, then the add.
    apply(mk(7'b0000011, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0);
    a = mk(7'b0110011, 5'd6, 5'd5, 5'd7);
    apply(a, 1'b0, 1'b0);
    apply(a, 1'b0, 1'b0);
    // False matches: lui rs1 slot, addi rs2 slot, load to x0.
    apply(mk(7'b0000011, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0);
    apply(mk(7'b0110111, 5'd6, 5'd5, 5'd0), 1'b0, 1'b0);
    apply(mk(7'b0000011, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0);
    apply(mk(7'b0010011, 5'd6, 5'd1, 5'd5), 1'b0, 1'b0);
    apply(mk(7'b0000011, 5'd0, 5'd1, 5'd0), 1'b0, 1'b0);
    apply(mk(7'b0110011, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0);
    // Flush beats load-use.
    apply(mk(7'b0000011, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0);
    apply(mk(7'b0110011, 5'd6, 5'd5, 5'd7), 1'b0, 1'b1);
    // Hold for three cycles with flush pulsed and ID changing, then release.
    apply(mk(7'b0110011, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
    apply(mk(7'b0010011, 5'd4, 5'd2, 5'd0), 1'b1, 1'b0);
    apply(mk(7'b0100011, 5'd0, 5'd2, 5'd3), 1'b1, 1'b1);
    apply(mk(7'b1100011, 5'd0, 5'd3, 5'd1), 1'b1, 1'b0);
    apply(mk(7'b0110011, 5'd9, 5'd8, 5'd7), 1'b0, 1'b0);
    // Back-to-back dependent loads: one bubble each.
    apply(mk(7'b0000011, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0);
    b = mk(7'b0000011, 5'd6, 5'd5, 5'd0);
    apply(b, 1'b0, 1'b0);
    apply(b, 1'b0, 1'b0);
    a = mk(7'b0110011, 5'd7, 5'd6, 5'd1);
    apply(a, 1'b0, 1'b0);
    apply(a, 1'b0, 1'b0);

    // Random traffic; long enough to saturate both counters.
    for (int n = 0; n < 3000; n++) begin
      apply(rnd_inst(), ($urandom % 8 == 0), ($urandom % 8 == 0));
    end

    // Asynchronous reset while EX holds a valid instruction.
    apply(mk(7'b0110011, 5'd1, 5'd2, 5'd3), 1'b0, 1'b1);
    apply(mk(7'b0110011, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_ex = bub(); m_lu = 0; m_fl = 0;
    for (int n = 0; n < 200; n++) begin
      apply(rnd_inst(), ($urandom % 8 == 0), ($urandom % 8 == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core, with integrated load-use hazard detection and bubble/flush insertion.
- Captures decoded operands, register indices, immediate and control from ID.
- Its outputs `rs1_ex`, `rs2_ex`, `opcode_ex`, `RegWrite_ex` and `MemRead_ex` feed the EX-stage forwarding unit and ALU operand muxes.
- Holds two saturating event counters (load-use bubbles, flush bubbles) for performance debug.

Parameters:
- XLEN, 32, datapath width (PC, register data, immediate).
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_id  in  1  ID holds a real instruction.
- pc_id  in  XLEN  PC of the ID instruction.
- opcode_id  in  7  opcode.
- funct3_id  in  3  funct3.
- funct7b5_id  in  1  instr[30].
- rs1_id, rs2_id, rd_id  in  5 each  register indices.
- rs1_data_id, rs2_data_id  in  XLEN each  register file read data.
- imm_id  in  XLEN  sign-extended immediate.
- RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id, ALUSrc_id, Branch_id, Jump_id  in  1 each  decoded control.
- stall_i  in  1  downstream hold (memory wait); freezes this register.
- flush_i  in  1  branch/jump taken in EX; kills the ID instruction.
- stall_o  out  1  load-use stall request to PC and IF/ID (combinational).
- valid_ex, pc_ex, opcode_ex, funct3_ex, funct7b5_ex, rs1_ex, rs2_ex, rd_ex, rs1_data_ex, rs2_data_ex, imm_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex, ALUSrc_ex, Branch_ex, Jump_ex  out  (matching ID widths)  registered EX copies.
- lu_cnt  out  CNT_W  load-use bubble count.
- flush_cnt  out  CNT_W  flush bubble count.

Behaviour:
- **Bubble value** (also the reset value of every registered output):
  - `valid_ex` = 0, `opcode_ex` = 7'b0010011 (addi NOP), `rs1_ex`/`rs2_ex`/`rd_ex` = 0.
  - All control bits 0; `pc_ex`/data/imm/funct fields 0.
  - `lu_cnt` and `flush_cnt` reset to 0.
- **Source use by ID opcode:**
  - `uses_rs1` = opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
  - `uses_rs2` = opcode in {0110011 R, 0100011 S, 1100011 B}.
- **Load-use hazard** (`lu_hz`) = `valid_id` & `MemRead_ex` & (`rd_ex` != 0) & ((`uses_rs1` & `rd_ex`==`rs1_id`) | (`uses_rs2` & `rd_ex`==`rs2_id`)).
- **stall_o** = `lu_hz` & ~`flush_i`. It is combinational from registered EX state plus ID inputs. Upstream ORs it with `stall_i`.
- **Per-edge update priority** (asynchronous reset overrides all):
  1. `stall_i`=1: hold every register; counters unchanged; `flush_i` is ignored this cycle (the branch stays in EX and re-asserts).
  2. `flush_i`=1: load bubble; `flush_cnt`++ (saturating).
  3. `lu_hz`=1: load bubble; `lu_cnt`++ (saturating). The ID instruction is held upstream and reloaded next cycle.
  4. Otherwise: capture all ID fields. `valid_ex` = `valid_id`; if `valid_id`=0, load bubble instead (no count).
- **Stall length:**
  - The load-use stall is exactly one cycle: after the bubble, `MemRead_ex`=0, so `lu_hz` drops.
  - Back-to-back loads with dependency still give exactly one bubble each.
- **Latency:** one cycle ID to EX.
- **Counters:** saturate at 2^CNT_W-1 and never wrap.
- **Reset mid-operation:** outputs go to bubble immediately (asynchronous); `stall_o` evaluates to 0 because `MemRead_ex`=0.
- **rd=x0:** a load to x0 never stalls.

Decomposition:
- Shared package `rv_pkg`:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - NOP_OPCODE;
  - XLEN default.
- One sub-module `load_use_detect` (combinational `lu_hz` and `uses_rs1`/`uses_rs2` decode), reusable by the decoder.
- Counters stay inline.

Test Plan:
- Reset: assert `rst_n`=0 mid-stream with `valid_ex`=1 -> all EX outputs immediately bubble (`opcode_ex`=0010011, `rd_ex`=0), counters 0, `stall_o`=0.
- Load-use:
  - Setup: EX holds lw x5 (`MemRead_ex`=1, `rd_ex`=5); ID add x6,x5,x7.
  - Same cycle: `stall_o`=1.
  - Next edge: `valid_ex`=0, `rd_ex`=0, `lu_cnt`=1.
  - Following edge: `opcode_ex`=0110011, `rs1_ex`=5, `rd_ex`=6, `stall_o`=0.
- False-match suppression:
  - Setup: EX lw x5; ID lui x6 with instr bits[19:15]=5 -> `stall_o`=0.
  - Also ID addi x6,x1,imm with bits[24:20]=5 -> `stall_o`=0.
  - Also EX lw x0 with ID add x1,x0,x0 -> `stall_o`=0.
- Flush priority: `flush_i`=1 together with a load-use condition -> `stall_o`=0; next edge loads bubble, `flush_cnt`=1, `lu_cnt` unchanged.
- Hold: `stall_i`=1 for 3 cycles with `flush_i` pulsed and ID fields changing -> all EX outputs and counters frozen. On release, the ID value present at that edge is captured.
- Saturation: preload `lu_cnt` to 0xFFFE via 65534 hazards (or `force`), trigger 2 more -> `lu_cnt`=0xFFFF and it stays there.
